// File: rtl/chip8_vga_pkg.sv
// rtl/chip8_vga_pkg.sv - shared timing constants and fetch FSM encoding for the CHIP-8 VGA scanout
package chip8_vga_pkg;

  localparam int H_ACTIVE     = 640;
  localparam int H_FP_END     = 656;
  localparam int H_SYNC_END   = 752;
  localparam int H_TOTAL      = 800;

  localparam int V_ACTIVE     = 480;
  localparam int V_SYNC_START = 490;
  localparam int V_SYNC_END   = 492;
  localparam int V_TOTAL      = 525;

  localparam int FB_W          = 64;
  localparam int FB_H          = 32;
  localparam int SCALE         = 10;
  localparam int BYTES_PER_ROW = 8;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_ADDR  = 2'd1,
    FETCH_WAIT  = 2'd2,
    FETCH_STORE = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/chip8_vga_timing.sv
// rtl/chip8_vga_timing.sv - 640x480 h/v counters, sync/active decode, CHIP-8 cell tracking and row fetch trigger
module chip8_vga_timing
  import chip8_vga_pkg::*;
#(
  parameter int V_OFFSET = 80
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  output logic [5:0] col,
  output logic [4:0] row,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       active,
  output logic       in_window,
  output logic       fetch_start
);

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_ACT     = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYNC_LO = 10'(H_FP_END);
  localparam logic [9:0] H_SYNC_HI = 10'(H_SYNC_END);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_ACT     = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNC_LO = 10'(V_SYNC_START);
  localparam logic [9:0] V_SYNC_HI = 10'(V_SYNC_END);
  localparam logic [9:0] WIN_TOP   = 10'(V_OFFSET);
  localparam logic [9:0] WIN_END   = 10'(V_OFFSET + FB_H * SCALE);
  localparam logic [3:0] SUB_LAST  = 4'(SCALE - 1);

  logic [9:0] h;
  logic [9:0] v;
  logic [9:0] v_next;
  logic [3:0] hsub;
  logic [3:0] vsub;
  logic       at_fetch_col;
  logic       next_in_window;

  assign v_next         = (v == V_LAST) ? 10'd0 : v + 10'd1;
  assign at_fetch_col   = tick && (h == H_ACT);
  assign next_in_window = (v_next > WIN_TOP) && (v_next < WIN_END);

  // The trigger looks ahead to the line about to start, so the row is in place before h wraps.
  always_comb begin
    fetch_start = 1'b0;
    if (at_fetch_col) begin
      if (v_next == WIN_TOP) begin
        fetch_start = 1'b1;
      end else if (next_in_window && vsub == SUB_LAST) begin
        fetch_start = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h    <= 10'd0;
      v    <= 10'd0;
      hsub <= 4'd0;
      col  <= 6'd0;
    end else if (tick) begin
      if (h == H_LAST) begin
        h    <= 10'd0;
        hsub <= 4'd0;
        col  <= 6'd0;
        v    <= v_next;
      end else begin
        h <= h + 10'd1;
        if (hsub == SUB_LAST) begin
          hsub <= 4'd0;
          col  <= col + 6'd1;
        end else begin
          hsub <= hsub + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row  <= 5'd0;
      vsub <= 4'd0;
    end else if (at_fetch_col) begin
      if (v_next == WIN_TOP) begin
        row  <= 5'd0;
        vsub <= 4'd0;
      end else if (next_in_window) begin
        if (vsub == SUB_LAST) begin
          vsub <= 4'd0;
          row  <= row + 5'd1;
        end else begin
          vsub <= vsub + 4'd1;
        end
      end
    end
  end

  assign hsync_n   = !((h >= H_SYNC_LO) && (h < H_SYNC_HI));
  assign vsync_n   = !((v >= V_SYNC_LO) && (v < V_SYNC_HI));
  assign active    = (h < H_ACT) && (v < V_ACT);
  assign in_window = (h < H_ACT) && (v >= WIN_TOP) && (v < WIN_END);

endmodule

// File: rtl/chip8_vga_scanout.sv
// rtl/chip8_vga_scanout.sv - CHIP-8 framebuffer to VGA scanout: row fetch FSM, line buffer, registered video outputs
module chip8_vga_scanout
  import chip8_vga_pkg::*;
#(
  parameter logic [11:0] FB_BASE  = 12'hF00,
  parameter int          MEM_LAT  = 1,
  parameter int          V_OFFSET = 80
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        timer_vga_tick,
  output logic [11:0] vga_mem_addr,
  input  logic [7:0]  vga_mem_data,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_active,
  output logic        vga_pixel
);

  localparam logic [1:0] LAT = 2'(MEM_LAT);

  logic [5:0]   col;
  logic [4:0]   row;
  logic         hsync_n;
  logic         vsync_n;
  logic         active;
  logic         in_window;
  logic         fetch_start;
  logic         pixel_next;

  fetch_state_e state;
  logic [2:0]   byte_idx;
  logic [1:0]   wait_cnt;
  logic [7:0]   linebuf [BYTES_PER_ROW];

  chip8_vga_timing #(
    .V_OFFSET (V_OFFSET)
  ) u_timing (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (timer_vga_tick),
    .col         (col),
    .row         (row),
    .hsync_n     (hsync_n),
    .vsync_n     (vsync_n),
    .active      (active),
    .in_window   (in_window),
    .fetch_start (fetch_start)
  );

  assign pixel_next = in_window & linebuf[col[5:3]][3'd7 - col[2:0]];

  // Runs at clk rate; a trigger arriving mid-fetch is dropped and the current row completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= FETCH_IDLE;
      byte_idx     <= 3'd0;
      wait_cnt     <= 2'd0;
      vga_mem_addr <= FB_BASE;
      for (int i = 0; i < BYTES_PER_ROW; i++) begin
        linebuf[i] <= 8'h00;
      end
    end else begin
      case (state)
        FETCH_IDLE: begin
          if (fetch_start) begin
            byte_idx <= 3'd0;
            state    <= FETCH_ADDR;
          end
        end
        FETCH_ADDR: begin
          vga_mem_addr <= FB_BASE + {4'b0, row, 3'b0} + {9'b0, byte_idx};
          wait_cnt     <= 2'd1;
          state        <= FETCH_WAIT;
        end
        FETCH_WAIT: begin
          if (wait_cnt == LAT) begin
            state <= FETCH_STORE;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        FETCH_STORE: begin
          linebuf[byte_idx] <= vga_mem_data;
          if (byte_idx == 3'd7) begin
            state <= FETCH_IDLE;
          end else begin
            byte_idx <= byte_idx + 3'd1;
            state    <= FETCH_ADDR;
          end
        end
        default: state <= FETCH_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_hsync  <= 1'b1;
      vga_vsync  <= 1'b1;
      vga_active <= 1'b0;
      vga_pixel  <= 1'b0;
    end else if (timer_vga_tick) begin
      vga_hsync  <= hsync_n;
      vga_vsync  <= vsync_n;
      vga_active <= active;
      vga_pixel  <= pixel_next;
    end
  end

endmodule

// File: doc/chip8_vga_scanout.md
Name: chip8_vga_scanout

Overview:
Display scanout stage downstream of the GPU/memory pair. It reads the 64x32 monochrome CHIP-8 framebuffer through the memory's dedicated read-only VGA port (vga_addr/vga_data). It generates 640x480@60 VGA timing, paced by timer_vga_tick. Each CHIP-8 pixel is scaled 10x10, giving a 640x320 window centred vertically with 80 lines of black above and below.

Parameters:
FB_BASE, 12'hF00, byte address of framebuffer row 0 byte 0; row-major, 8 bytes/row, bit 7 = leftmost pixel.
MEM_LAT, 1, clk cycles from vga_mem_addr change to valid vga_mem_data (1..3).
V_OFFSET, 80, first active screen line of the CHIP-8 window.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active low
timer_vga_tick  in  1  pixel-rate enable (one-clk pulse per VGA pixel)
vga_mem_addr  out  12  framebuffer byte address to memory VGA port
vga_mem_data  in  8  byte read from memory, valid MEM_LAT clk after address
vga_hsync  out  1  horizontal sync, active low
vga_vsync  out  1  vertical sync, active low
vga_active  out  1  high inside the 640x480 visible area
vga_pixel  out  1  pixel value (1 = lit); 0 outside the CHIP-8 window and in blanking

Behaviour:
- Reset (async, rst_n=0): hsync=1, vsync=1, active=0, pixel=0, vga_mem_addr=FB_BASE. h/v counters=0, fetch FSM=IDLE, line buffer cleared. Reset mid-fetch aborts the fetch; no partial-row recovery.
- Counters advance only on clk edges with timer_vga_tick=1. h counts 0..799 and wraps. v increments on h wrap, counts 0..524 and wraps.
- Timing: visible h<640 && v<480. hsync low for h in [656,752). vsync low for v in [490,492).
- Window: v in [V_OFFSET, V_OFFSET+320), h<640. Track col (0..63) and hsub (0..9) alongside h; no dividers. Track row (0..31) and vsub (0..9) per line; no dividers.
- Outputs are registered on the tick, one tick after the counter value they describe. hsync, vsync, active and pixel stay mutually aligned.
- pixel = linebuf[col[5:3]][7-col[2:0]] inside the window, else 0.
- Line buffer: 8 x 8-bit registers holding the current CHIP-8 row.
- Fetch trigger: tick with h==640 on line v. Target line t=v+1 (0 after 524).
  - t==V_OFFSET: set row=0, vsub=0, fetch.
  - t inside the window: vsub++. On wrap 9->0, row++ and fetch.
  - t outside the window: no fetch.
- Fetch FSM (clk-rate, independent of tick): IDLE -> ADDR -> WAIT (MEM_LAT cycles) -> STORE -> ADDR, repeated for bytes 0..7, then IDLE.
  - Address for byte i = FB_BASE + {row,3'b0} + i, in 12-bit modulo arithmetic.
  - STORE writes linebuf[i].
  - Worst case 8*(MEM_LAT+2) clk ≤ 40 clk. This completes inside the 160-tick hblank for any tick rate ≤ clk.
- The line buffer is written only during hblank, so there is no tearing within a line. Framebuffer changes between rows appear on the next row fetched.
- vga_mem_addr holds its last value when IDLE. The memory port is read-only and side-effect free.
- A trigger while the FSM is not IDLE cannot occur under legal tick rates. The FSM ignores it and completes the current fetch.

Decomposition:
- Package chip8_vga_pkg holds:
  - H_ACTIVE=640, H_FP_END=656, H_SYNC_END=752, H_TOTAL=800
  - V_ACTIVE=480, V_SYNC_START=490, V_SYNC_END=492, V_TOTAL=525
  - FB_W=64, FB_H=32, SCALE=10, BYTES_PER_ROW=8
  - the fetch-FSM state enum
- Sub-module chip8_vga_timing: h/v counters, sync/active generation, col/hsub/row/vsub tracking, fetch trigger pulse.
- The top level holds the fetch FSM, line buffer and output registers.

Test Plan:
- Reset: rst_n low for 5 clk, including once mid-fetch at line 79 -> hsync=1, vsync=1, active=0, pixel=0, addr=12'hF00 immediately (asynchronous); FSM IDLE after release.
- Sync timing, tick every clk -> hsync low exactly 96 ticks per 800; vsync low exactly 2 lines (1600 ticks) per 525 lines; active high 640 ticks per visible line.
- Fetch addressing -> line 79 h=640 issues F00..F07; line 89 issues F08..F0F; line 389 issues FF8..FFF; no addresses issued on lines 399..524 or 0..78.
- Pixel map: mem[F00]=8'h80, rest 0 -> pixel=1 only for h 0..9 on lines 80..89 (100 lit pixels/frame).
- Last pixel: mem[FFF]=8'h01 -> pixel=1 only for h 630..639 on lines 390..399.
- Rate/latency: tick every 2 clk with MEM_LAT=3, and tick every clk with MEM_LAT=1 -> identical per-tick output sequences; all bytes checkerboard 8'hAA produces alternating 10-pixel lit/dark runs.
